// File: rtl/shiftregister_pkg.sv
// Shared definitions for the 5-bit serial transmitter.
//   WORD_WIDTH  : width of the parallel word being serialized
//   LAST_INDEX  : bit index of the final serialized bit
//   state_t     : transmitter FSM states (IDLE, SHIFT)
package shiftregister_pkg;

    localparam int WORD_WIDTH = 5;
    localparam logic [2:0] LAST_INDEX = 3'(WORD_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bitcounter_mod5.sv
// Bit-position counter for the serializer; counts 0..4 and saturates at 4.
// Ports:
//   clockpulse : clock, rising edge
//   clear      : synchronous active-high reset, count returns to 0
//   enable     : advance the count (ignored once the last position is reached)
//   restart    : force the count back to 0 (start of a new word)
//   count[2:0] : current bit position
//   last       : high when count sits on the final bit position
module bitcounter_mod5
    import shiftregister_pkg::*;
(
    input  logic       clockpulse,
    input  logic       clear,
    input  logic       enable,
    input  logic       restart,
    output logic [2:0] count,
    output logic       last
);

    logic [2:0] count_r;

    // Position register: clear wins, then restart, then saturating increment.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            count_r <= 3'd0;
        end else if (restart) begin
            count_r <= 3'd0;
        end else if (enable && (count_r < LAST_INDEX)) begin
            count_r <= count_r + 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == LAST_INDEX);

endmodule

// File: rtl/shiftregister_5bit_transmitter.sv
// 5-bit parallel-in / serial-out transmitter, LSB first, with a ready/valid
// load handshake and a stall input. Back-to-back words stream with no gap
// when a new word is offered while the last bit of the current one leaves.
// Ports:
//   clockpulse   : clock, rising edge
//   clear        : synchronous active-high reset
//   loadValid    : parallel word on preset is offered
//   preset[4:0]  : parallel word, bit 0 sent first
//   loadReady    : combinational, a word offered now will be accepted
//   shiftEnable  : advance to the next bit when high, stall when low
//   serialOutput : registered serial data
//   serialValid  : registered, serialOutput carries a data bit
//   busy         : registered, FSM is in SHIFT
//   done         : registered one-cycle pulse after a word's last bit
//   out[4:0]     : registered shift-register contents (monitor only)
module shiftregister_5bit_transmitter
    import shiftregister_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clockpulse,
    input  logic                  clear,
    input  logic                  loadValid,
    input  logic [WORD_WIDTH-1:0] preset,
    output logic                  loadReady,
    input  logic                  shiftEnable,
    output logic                  serialOutput,
    output logic                  serialValid,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] out
);

    state_t                  state_r, next_state_s;
    logic [WORD_WIDTH-1:0]   out_r, next_out_s;
    logic                    sout_r, next_sout_s;
    logic                    svalid_r, next_svalid_s;
    logic                    busy_r, next_busy_s;
    logic                    done_r, next_done_s;

    logic [2:0]              count_s;
    logic                    last_s;
    logic                    word_end_s;
    logic                    ready_s;
    logic                    accept_s;

    // The final bit of the word is leaving on this edge.
    assign word_end_s = (state_r == SHIFT) && shiftEnable && last_s;
    assign ready_s    = !clear && ((state_r == IDLE) || word_end_s);
    assign accept_s   = loadValid && ready_s;
    assign loadReady  = ready_s;

    // Counter restarts on every accepted word and when a word finishes,
    // so it is back at 0 whenever the FSM idles.
    bitcounter_mod5 u_bitcounter (
        .clockpulse (clockpulse),
        .clear      (clear),
        .enable     ((state_r == SHIFT) && shiftEnable),
        .restart    (accept_s || word_end_s),
        .count      (count_s),
        .last       (last_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        next_state_s  = state_r;
        next_out_s    = out_r;
        next_sout_s   = sout_r;
        next_svalid_s = svalid_r;
        next_busy_s   = busy_r;
        next_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s  = SHIFT;
                    next_out_s    = preset;
                    next_sout_s   = preset[0];
                    next_svalid_s = 1'b1;
                    next_busy_s   = 1'b1;
                end else begin
                    next_state_s  = IDLE;
                end
            end
            SHIFT: begin
                if (!shiftEnable) begin
                    next_state_s  = SHIFT;
                end else if (count_s < LAST_INDEX) begin
                    // Zero-fill from the top; the next bit is the current out[1].
                    next_out_s    = {1'b0, out_r[WORD_WIDTH-1:1]};
                    next_sout_s   = out_r[1];
                end else begin
                    next_done_s   = 1'b1;
                    if (accept_s) begin
                        next_state_s  = SHIFT;
                        next_out_s    = preset;
                        next_sout_s   = preset[0];
                        next_svalid_s = 1'b1;
                        next_busy_s   = 1'b1;
                    end else begin
                        next_state_s  = IDLE;
                        next_sout_s   = IDLE_LEVEL;
                        next_svalid_s = 1'b0;
                        next_busy_s   = 1'b0;
                    end
                end
            end
            default: begin
                next_state_s  = IDLE;
                next_out_s    = {WORD_WIDTH{1'b0}};
                next_sout_s   = IDLE_LEVEL;
                next_svalid_s = 1'b0;
                next_busy_s   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output registers; clear discards any partial word.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            out_r    <= {WORD_WIDTH{1'b0}};
            sout_r   <= IDLE_LEVEL;
            svalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            out_r    <= next_out_s;
            sout_r   <= next_sout_s;
            svalid_r <= next_svalid_s;
            busy_r   <= next_busy_s;
            done_r   <= next_done_s;
        end
    end

    assign out          = out_r;
    assign serialOutput = sout_r;
    assign serialValid  = svalid_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_shiftregister_5bit_transmitter.sv
// Table-driven bench for shiftregister_5bit_transmitter, with a stall
// sequence and a loopback right-shift receiver model checked on each done.
module tb_shiftregister_5bit_transmitter;

    logic       clk = 1'b0;
    logic       clr;
    logic       lv;
    logic [4:0] pre;
    logic       se;
    logic       rdy, so, sv, bsy, dn;
    logic [4:0] dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clr;
        logic       lv;
        logic [4:0] pre;
        logic       se;
        logic       cmp;   // word accepted here is expected to complete
        logic       rdy;   // expected loadReady before the edge
        logic       so;
        logic       sv;
        logic       bsy;
        logic       dn;
        logic [4:0] out;
    } vec_t;

    vec_t       vq[$];
    logic [4:0] exp_words[$];
    logic [4:0] rx = 5'd0;

    always #5 clk = ~clk;

    shiftregister_5bit_transmitter #(.IDLE_LEVEL(1'b0)) dut (
        .clockpulse   (clk),
        .clear        (clr),
        .loadValid    (lv),
        .preset       (pre),
        .loadReady    (rdy),
        .shiftEnable  (se),
        .serialOutput (so),
        .serialValid  (sv),
        .busy         (bsy),
        .done         (dn),
        .out          (dout)
    );

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic c, input logic l, input logic [4:0] p, input logic s,
                       input logic cm, input logic r, input logic o, input logic v,
                       input logic b, input logic d, input logic [4:0] ou);
        vec_t t;
        t = '{clr: c, lv: l, pre: p, se: s, cmp: cm, rdy: r, so: o, sv: v, bsy: b, dn: d, out: ou};
        vq.push_back(t);
    endtask

    // Loopback receiver: right shift, clocked by serialValid & shiftEnable.
    always @(posedge clk) begin
        if (sv && se) rx <= {so, rx[4:1]};
    end

    // On each done pulse the receiver must hold the oldest outstanding word.
    always @(negedge clk) begin
        if (dn === 1'b1) begin
            if (exp_words.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL loopback: done with no expected word, rx %b", rx);
            end else begin
                chk("loopback", rx, exp_words.pop_front());
            end
        end
    end

    initial begin
        logic se_pat[9];
        logic so_exp[8];
        se_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        so_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        clr = 1'b1; lv = 1'b0; pre = 5'd0; se = 1'b0;

        //   clr   lv    pre       se    cmp   rdy   so    sv    bsy   dn    out
        // reset for two cycles, the second with load/shift requests present
        add(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        add(1'b1, 1'b1, 5'b10101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        // word 10110 -> 0,1,1,0,1 then done
        add(1'b0, 1'b1, 5'b10110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10110);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b01011);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00101);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00010);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00001);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00001);
        // 00111 then 11000 offered on bit 4: ten back-to-back bits
        add(1'b0, 1'b1, 5'b00111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00111);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00011);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00001);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000);
        add(1'b0, 1'b1, 5'b11000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11000);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b01100);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00110);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00011);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00001);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001);
        // 11111, ignored mid-word load, then clear on bit 2
        add(1'b0, 1'b1, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b11111);
        add(1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b01111);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00111);
        add(1'b1, 1'b1, 5'b10101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);

        foreach (vq[i]) begin
            @(negedge clk);
            clr = vq[i].clr; lv = vq[i].lv; pre = vq[i].pre; se = vq[i].se;
            #1;
            chk($sformatf("v%0d loadReady", i), {4'd0, rdy}, {4'd0, vq[i].rdy});
            @(posedge clk);
            #1;
            if (vq[i].cmp) exp_words.push_back(vq[i].pre);
            chk($sformatf("v%0d serialOutput", i), {4'd0, so},  {4'd0, vq[i].so});
            chk($sformatf("v%0d serialValid", i),  {4'd0, sv},  {4'd0, vq[i].sv});
            chk($sformatf("v%0d busy", i),         {4'd0, bsy}, {4'd0, vq[i].bsy});
            chk($sformatf("v%0d done", i),         {4'd0, dn},  {4'd0, vq[i].dn});
            chk($sformatf("v%0d out", i),          dout,        vq[i].out);
        end

        // Stall: word 11001, bit 1 held for three extra cycles.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            clr = 1'b0; lv = (i == 0); pre = 5'b11001; se = se_pat[i];
            @(posedge clk);
            #1;
            if (i == 0) exp_words.push_back(5'b11001);
            if (i < 8) begin
                chk($sformatf("stall%0d serialOutput", i), {4'd0, so}, {4'd0, so_exp[i]});
                chk($sformatf("stall%0d serialValid", i),  {4'd0, sv}, 5'd1);
                chk($sformatf("stall%0d busy", i),         {4'd0, bsy}, 5'd1);
                chk($sformatf("stall%0d done", i),         {4'd0, dn}, 5'd0);
            end else begin
                chk("stall_end serialValid", {4'd0, sv}, 5'd0);
                chk("stall_end busy",        {4'd0, bsy}, 5'd0);
                chk("stall_end done",        {4'd0, dn}, 5'd1);
            end
        end

        @(negedge clk);
        lv = 1'b0; se = 1'b0;
        @(posedge clk);
        #1;
        chk("done_single_cycle", {4'd0, dn}, 5'd0);
        @(negedge clk);
        chk("words_outstanding", 5'(exp_words.size()), 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftregister_5bit_transmitter.md
SHIFTREGISTER_5BIT_TRANSMITTER -- requirements
Module: shiftregister_5bit_transmitter

Interface
REQ-001 Parameter: IDLE_LEVEL, 0, value driven on serialOutput when no bit is being sent.
REQ-002 Port: clockpulse  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: clear  input  1  reset, synchronous, active-high.
REQ-004 Port: loadValid  input  1  parallel word offered on preset.
REQ-005 Port: preset  input  5  parallel word to serialize; bit 0 is sent first.
REQ-006 Port: loadReady  output  1  block accepts a word this cycle; combinational.
REQ-007 Port: shiftEnable  input  1  advance to the next bit when high; stall when low.
REQ-008 Port: serialOutput  output  1  registered serial data to the right-shift receiver.
REQ-009 Port: serialValid  output  1  registered; high while serialOutput carries a data bit.
REQ-010 Port: busy  output  1  registered; high in SHIFT state.
REQ-011 Port: done  output  1  registered; one-cycle pulse after the last bit of a word.
REQ-012 Port: out  output  5  registered shift-register contents; monitor only.

Function
REQ-013 Accept a word when loadValid and loadReady are both high at a rising edge.
REQ-014 Drive loadReady high in IDLE, or in SHIFT when bitCount=4 and shiftEnable=1; otherwise low.
REQ-015 Use two FSM states: IDLE and SHIFT.
REQ-016 On acceptance: load out<=preset, bitCount<=0, serialOutput<=preset[0], serialValid<=1, busy<=1, state<=SHIFT.
REQ-017 In SHIFT with shiftEnable=1 and bitCount<4: shift out right (MSB filled with 0), increment bitCount, serialOutput<=new out[0].
REQ-018 In SHIFT with shiftEnable=0: hold out, bitCount, serialOutput and serialValid unchanged.
REQ-019 Bit k (k=0..4) of an accepted word is on serialOutput for exactly one enabled cycle. Latency from acceptance edge to bit 0 is one edge.
REQ-020 In SHIFT, bitCount=4, shiftEnable=1 and no new load: go to IDLE, serialOutput<=IDLE_LEVEL, serialValid<=0, busy<=0, done<=1.
REQ-021 In the same condition with a load accepted: apply REQ-016 and assert done<=1; the next word starts with no gap and busy stays high.
REQ-022 done is high for one cycle only; it is 0 in every other cycle.
REQ-023 loadValid in SHIFT when loadReady=0 is ignored; the word in flight is not corrupted.
REQ-024 bitCount is 3 bits and never exceeds 4.

Reset
REQ-025 While clear=1 at a rising edge: state<=IDLE, out<=0, bitCount<=0, serialOutput<=IDLE_LEVEL, serialValid<=0, busy<=0, done<=0.
REQ-026 clear overrides load and shift in the same cycle, including mid-word; the partial word is discarded.
REQ-027 loadReady is 0 while clear=1.

Structure
REQ-028 Put the state enum (IDLE, SHIFT) and the constant WORD_WIDTH=5 in the shared package shiftregister_pkg.
REQ-029 Implement bitCount as sub-module bitcounter_mod5, with ports clockpulse, clear, enable, restart, count[2:0] and last.

Verification
REQ-030 clear for 2 cycles, then release -> all outputs at reset values; loadReady=1; serialOutput=IDLE_LEVEL.
REQ-031 Load 5'b10110 with shiftEnable=1 -> serialOutput 0,1,1,0,1 over 5 cycles with serialValid=1, then done=1 for 1 cycle and busy=0.
REQ-032 Load 5'b11001, hold shiftEnable=0 for 3 cycles after bit 1 -> bit 1 (0) held 4 cycles, sequence otherwise intact; total 8 cycles valid.
REQ-033 Load 5'b00111, then 5'b11000 offered during bit 4 -> 10 consecutive valid bits 1,1,1,0,0,0,0,0,1,1; done pulses after each word.
REQ-034 Load 5'b11111, assert clear at bit 2 -> next cycle serialOutput=IDLE_LEVEL, out=0, busy=0, no done pulse.
REQ-035 Loopback into the 5-bit right-shift receiver clocked by serialValid&shiftEnable -> receiver out equals each loaded word when done=1.
